// File: rtl/run_sequencer.sv
// run_sequencer: holds the core in reset, pulses its start and counts run cycles until halt or timeout.
// Optional Abort input is enabled by defining RUN_SEQ_ABORT_EN.
module run_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 65535,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          CoreAck,
`ifdef RUN_SEQ_ABORT_EN
    input  logic          Abort,
`endif
    output logic          CoreReset,
    output logic          CoreStart,
    output logic          Busy,
    output logic          Done,
    output logic          Timeout,
    output logic [CW-1:0] CycleCt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    typedef enum logic [2:0] {sIdle, sReset, sLaunch, sRun, sDone} state_t;
    state_t state;
    logic [RW-1:0] rstCt;
    logic abortReq, inRun, atMax, endRun, endTimeout;
    if (RST_CYCLES < 1 || MAX_CYCLES < 1 || longint'(MAX_CYCLES) > (longint'(1) << CW) - 1) begin : gBadParams
        $error("run_sequencer: RST_CYCLES must be >= 1 and MAX_CYCLES must fit in 1..2^CW-1");
    end
`ifdef RUN_SEQ_ABORT_EN
    assign abortReq = Abort;
`else
    assign abortReq = 1'b0;
`endif
    // Decide whether the current run ends this edge and why; abort beats halt, halt beats timeout
    always_comb begin
        inRun = state == sReset || state == sLaunch || state == sRun;
        atMax = CycleCt == CW'(MAX_CYCLES - 1);
        endRun = inRun && (abortReq || (state == sRun && (CoreAck || atMax)));
        endTimeout = abortReq || !CoreAck;
    end
    // Sequencer state and all registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= sIdle;
            CoreReset <= 1'b1;
            CoreStart <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b0;
            Timeout <= 1'b0;
            CycleCt <= '0;
            rstCt <= '0;
        end else if (endRun) begin
            state <= sDone;
            CoreReset <= abortReq;
            CoreStart <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b1;
            Timeout <= endTimeout;
            if (!abortReq && !CoreAck) CycleCt <= CW'(MAX_CYCLES);
        end else begin
            case (state)
                sIdle, sDone: if (Start) begin
                    state <= sReset;
                    CoreReset <= 1'b1;
                    Busy <= 1'b1;
                    Done <= 1'b0;
                    Timeout <= 1'b0;
                    CycleCt <= '0;
                    rstCt <= '0;
                end
                sReset: if (rstCt == RW'(RST_CYCLES - 1)) begin
                    state <= sLaunch;
                    CoreReset <= 1'b0;
                    CoreStart <= 1'b1;
                end else begin
                    rstCt <= rstCt + 1'b1;
                end
                sLaunch: begin
                    state <= sRun;
                    CoreStart <= 1'b0;
                end
                sRun: CycleCt <= CycleCt + 1'b1;
                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed scoreboard bench for run_sequencer (MAX_CYCLES=20, RST_CYCLES=4).
module tb_run_sequencer;
    localparam int MAXC = 20;
    localparam int RSTC = 4;
    logic Clk, Reset, Start, CoreAck;
    logic CoreReset, CoreStart, Busy, Done, Timeout;
    logic [15:0] CycleCt;
    int checks = 0;
    int errors = 0;
    typedef struct {int cyc; int to; int lat;} exp_t;
    exp_t sb[$];
`ifdef RUN_SEQ_ABORT_EN
    logic Abort;
`endif

    run_sequencer #(.RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CW(16)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .CoreAck(CoreAck),
`ifdef RUN_SEQ_ABORT_EN
        .Abort(Abort),
`endif
        .CoreReset(CoreReset),
        .CoreStart(CoreStart),
        .Busy(Busy),
        .Done(Done),
        .Timeout(Timeout),
        .CycleCt(CycleCt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, ".coreReset"}, CoreReset, 1);
        chk({tag, ".coreStart"}, CoreStart, 0);
        chk({tag, ".busy"}, Busy, 0);
        chk({tag, ".done"}, Done, 0);
        chk({tag, ".timeout"}, Timeout, 0);
        chk({tag, ".cycleCt"}, CycleCt, 0);
    endtask

    task automatic startRun();
        Start = 1'b1;
        tick();
        chk("enterReset.busy", Busy, 1);
        chk("enterReset.done", Done, 0);
        chk("enterReset.timeout", Timeout, 0);
        chk("enterReset.cycleCt", CycleCt, 0);
    endtask

    task automatic resetLaunch(input logic early);
        int rc = 0;
        CoreAck = early;
        while (CoreReset && Busy && rc < 20) begin
            rc++;
            tick();
        end
        chk("resetCycles", rc, RSTC);
        chk("launch.coreStart", CoreStart, 1);
        chk("launch.coreReset", CoreReset, 0);
        tick();
        CoreAck = 1'b0;
        chk("run.coreStart", CoreStart, 0);
        chk("run.busy", Busy, 1);
        chk("run.cycleCt", CycleCt, 0);
    endtask

    task automatic runTo(input int ackAt);
        int n = 0;
        exp_t e;
        if (ackAt < 0) e = '{cyc: MAXC, to: 1, lat: MAXC + 1};
        else e = '{cyc: ackAt, to: 0, lat: ackAt + 2};
        sb.push_back(e);
        while (!Done && n < 200) begin
            CoreAck = ackAt >= 0 && int'(CycleCt) == ackAt;
            tick();
            n++;
        end
        CoreAck = 1'b0;
        e = sb.pop_front();
        chk("done", Done, 1);
        chk("timeout", Timeout, e.to);
        chk("cycleCt", CycleCt, e.cyc);
        chk("launchToDone", n + 1, e.lat);
        chk("done.busy", Busy, 0);
        chk("done.coreReset", CoreReset, 0);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        Start = 1'b0;
        CoreAck = 1'b0;
`ifdef RUN_SEQ_ABORT_EN
        Abort = 1'b0;
`endif
        #2;
        chkResetVals("reset");
        tick();
        Reset = 1'b0;
        tick();
        chkResetVals("idle");
        // halt after 10 run cycles
        startRun();
        Start = 1'b0;
        resetLaunch(1'b0);
        runTo(10);
        tick();
        chk("doneHold.done", Done, 1);
        chk("doneHold.cycleCt", CycleCt, 10);
        // timeout with no halt
        startRun();
        Start = 1'b0;
        resetLaunch(1'b0);
        runTo(-1);
        // halt coincident with timeout: halt wins
        startRun();
        Start = 1'b0;
        resetLaunch(1'b0);
        runTo(MAXC - 1);
        // stale ack during RESET/LAUNCH is ignored
        startRun();
        Start = 1'b0;
        resetLaunch(1'b1);
        runTo(5);
        // Start held high: back-to-back runs with one-cycle Done
        startRun();
        resetLaunch(1'b0);
        runTo(3);
        tick();
        chk("b2b.done", Done, 0);
        chk("b2b.busy", Busy, 1);
        chk("b2b.cycleCt", CycleCt, 0);
        resetLaunch(1'b0);
        runTo(3);
        Start = 1'b0;
        tick();
        chk("b2bEnd.done", Done, 1);
        // async reset mid-run at CycleCt=7
        startRun();
        Start = 1'b0;
        resetLaunch(1'b0);
        n = 0;
        while (CycleCt != 16'd7 && n < 50) begin
            tick();
            n++;
        end
        chk("midRun.cycleCt", CycleCt, 7);
        #2 Reset = 1'b1;
        #1;
        chkResetVals("asyncReset");
        tick();
        Reset = 1'b0;
        tick();
`ifdef RUN_SEQ_ABORT_EN
        // abort mid-run at CycleCt=7
        startRun();
        Start = 1'b0;
        resetLaunch(1'b0);
        n = 0;
        while (CycleCt != 16'd7 && n < 50) begin
            tick();
            n++;
        end
        Abort = 1'b1;
        CoreAck = 1'b1;
        tick();
        Abort = 1'b0;
        CoreAck = 1'b0;
        chk("abort.done", Done, 1);
        chk("abort.timeout", Timeout, 1);
        chk("abort.cycleCt", CycleCt, 7);
        chk("abort.coreReset", CoreReset, 1);
        chk("abort.busy", Busy, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
